// File: rtl/prog_seq_counter.sv
// prog_seq_counter
//   Programmable sequence counter. A DEPTH-entry table of W-bit codes is
//   walked forward or backward between index 0 and the active last entry.
//   Each cycle q is registered from the table entry at the next index. A
//   table write made in the same cycle is visible on q immediately.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous, active-high reset
//   en       in   advance one step this cycle
//   dir      in   0 = forward, 1 = reverse
//   ld       in   synchronous load of ld_idx (priority over en)
//   ld_idx   in   index to load; beyond the last entry loads 0 and sets err
//   last_idx in   final active entry, clamped to DEPTH-1
//   wr_en    in   table write strobe
//   wr_addr  in   entry to write; addresses >= DEPTH are ignored
//   wr_data  in   code to write
//   err_clr  in   clears err (a same-cycle set wins)
//   q        out  registered code of the current entry
//   idx      out  registered current index
//   wrap     out  one-cycle pulse after a wrapping step
//   err      out  sticky illegal-load flag
//
// Optional feature (macro PROG_SEQ_COUNTER_ONESHOT_EN)
//   oneshot  in   a step that would wrap instead holds idx and sets done
//   done     out  cleared by ld or rst
module prog_seq_counter #(
  parameter int unsigned W     = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  logic          ld,
  input  logic [AW-1:0] ld_idx,
  input  logic [AW-1:0] last_idx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          err_clr,
  output logic [W-1:0]  q,
  output logic [AW-1:0] idx,
  output logic          wrap,
  output logic          err
`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
  ,
  input  logic          oneshot,
  output logic          done
`endif
);

  logic [W-1:0]  tbl [DEPTH];
  logic [AW-1:0] l_clamp;
  logic [AW-1:0] idx_nxt;
  logic          wrap_nxt;
  logic          err_set;
  logic          wr_ok;
  logic [W-1:0]  q_nxt;

  always_comb begin
    if ({1'b0, last_idx} >= (AW+1)'(DEPTH)) l_clamp = AW'(DEPTH - 1);
    else                                    l_clamp = last_idx;
  end

  assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW+1)'(DEPTH));

`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
  logic done_set;
`endif

  always_comb begin
    idx_nxt  = idx;
    wrap_nxt = 1'b0;
    err_set  = 1'b0;
`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
    done_set = 1'b0;
`endif
    if (ld) begin
      if (ld_idx > l_clamp) begin
        idx_nxt = '0;
        err_set = 1'b1;
      end else begin
        idx_nxt = ld_idx;
      end
    end else if (en) begin
      if (!dir) begin
        // idx above a lowered last entry also counts as a wrap to 0
        if (idx < l_clamp) begin
          idx_nxt = idx + AW'(1);
        end else begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end
      end else begin
        // only leaving index 0 is a wrap; idx above L just snaps back to L
        if (idx != '0 && idx <= l_clamp) begin
          idx_nxt = idx - AW'(1);
        end else begin
          idx_nxt  = l_clamp;
          wrap_nxt = (idx == '0);
        end
      end
`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
      if (oneshot && wrap_nxt) begin
        idx_nxt  = idx;
        wrap_nxt = 1'b0;
        done_set = 1'b1;
      end
`endif
    end
  end

  // write-through: a same-cycle write to the next entry bypasses the table
  always_comb begin
    q_nxt = tbl[idx_nxt];
    if (wr_ok && wr_addr == idx_nxt) q_nxt = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) tbl[i] <= W'(i);
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx  <= '0;
      q    <= '0;
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      idx  <= idx_nxt;
      q    <= q_nxt;
      wrap <= wrap_nxt;
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           done <= 1'b0;
    else if (ld)       done <= 1'b0;
    else if (done_set) done <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_prog_seq_counter.sv
// tb_prog_seq_counter
//   Directed bench for prog_seq_counter (W = 3, DEPTH = 4). Inputs change
//   1 time unit after each rising edge; outputs are checked at that point.
module tb_prog_seq_counter;

  localparam int unsigned W     = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          dir;
  logic          ld;
  logic [AW-1:0] ld_idx;
  logic [AW-1:0] last_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic          err_clr;
  logic [W-1:0]  q;
  logic [AW-1:0] idx;
  logic          wrap;
  logic          err;
`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
  logic          oneshot;
  logic          done;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  prog_seq_counter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .dir      (dir),
    .ld       (ld),
    .ld_idx   (ld_idx),
    .last_idx (last_idx),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .err_clr  (err_clr),
    .q        (q),
    .idx      (idx),
    .wrap     (wrap),
    .err      (err)
`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
    ,
    .oneshot  (oneshot),
    .done     (done)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // q, idx, wrap, err after one clock
  task automatic step_chk(input string tag, input int eq, input int ei, input int ew, input int ee);
    tick();
    check({tag, ".q"},    32'(q),    32'(eq));
    check({tag, ".idx"},  32'(idx),  32'(ei));
    check({tag, ".wrap"}, 32'(wrap), 32'(ew));
    check({tag, ".err"},  32'(err),  32'(ee));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b0; ld = 1'b0; ld_idx = '0;
    last_idx = 2'd3; wr_en = 1'b0; wr_addr = '0; wr_data = '0; err_clr = 1'b0;
`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
    oneshot = 1'b0;
`endif
    #13;
    check("rst.q",    32'(q),    0);
    check("rst.idx",  32'(idx),  0);
    check("rst.wrap", 32'(wrap), 0);
    check("rst.err",  32'(err),  0);
    rst = 1'b0;
    tick();

    // program table {0,1,2,7}: only entry 3 differs from reset identity
    wr_en = 1'b1; wr_addr = 2'd3; wr_data = 3'd7;
    step_chk("wr3", 0, 0, 0, 0);
    wr_en = 1'b0;

    // forward run
    en = 1'b1; dir = 1'b0;
    step_chk("fw1", 1, 1, 0, 0);
    step_chk("fw2", 2, 2, 0, 0);
    step_chk("fw3", 7, 3, 0, 0);
    step_chk("fw4", 0, 0, 1, 0);

    // reverse run from 0
    dir = 1'b1;
    step_chk("rv1", 7, 3, 1, 0);
    step_chk("rv2", 2, 2, 0, 0);
    step_chk("rv3", 1, 1, 0, 0);
    step_chk("rv4", 0, 0, 0, 0);
    step_chk("rv5", 7, 3, 1, 0);
    en = 1'b0;

    // illegal load, clear, legal load, set-with-clear
    ld = 1'b1; ld_idx = 2'd3; last_idx = 2'd2; dir = 1'b0;
    step_chk("ldbad", 0, 0, 0, 1);
    ld = 1'b0; err_clr = 1'b1;
    step_chk("clr", 0, 0, 0, 0);
    err_clr = 1'b0; ld = 1'b1; ld_idx = 2'd2;
    step_chk("ldok", 2, 2, 0, 0);
    ld_idx = 2'd3; err_clr = 1'b1; en = 1'b1;
    step_chk("setclr", 0, 0, 0, 1);
    ld = 1'b0; err_clr = 1'b1; en = 1'b0;
    step_chk("clr2", 0, 0, 0, 0);
    err_clr = 1'b0;

    // last_idx lowered below current idx
    ld = 1'b1; ld_idx = 2'd3; last_idx = 2'd3;
    step_chk("ld3a", 7, 3, 0, 0);
    ld = 1'b0; last_idx = 2'd1; en = 1'b1; dir = 1'b0;
    step_chk("lowfw", 0, 0, 1, 0);
    en = 1'b0; ld = 1'b1; last_idx = 2'd3;
    step_chk("ld3b", 7, 3, 0, 0);
    ld = 1'b0; last_idx = 2'd1; en = 1'b1; dir = 1'b1;
    step_chk("lowrv", 1, 1, 0, 0);

    // write to current entry while idle, then write-through on a step
    en = 1'b0; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 3'd5;
    step_chk("wrcur", 5, 1, 0, 0);
    last_idx = 2'd3; en = 1'b1; dir = 1'b0; wr_addr = 2'd2; wr_data = 3'd6;
    step_chk("wrthru", 6, 2, 0, 0);
    en = 1'b0; wr_en = 1'b0;
    step_chk("hold", 6, 2, 0, 0);

    // asynchronous reset mid-cycle at idx 2
    #2 rst = 1'b1;
    #1;
    check("arst.q",   32'(q),   0);
    check("arst.idx", 32'(idx), 0);
    #2 rst = 1'b0;
    en = 1'b1;
    step_chk("post1", 1, 1, 0, 0);
    step_chk("post2", 2, 2, 0, 0);
    step_chk("post3", 3, 3, 0, 0);
    step_chk("post4", 0, 0, 1, 0);
    en = 1'b0;

`ifdef PROG_SEQ_COUNTER_ONESHOT_EN
    oneshot = 1'b1; en = 1'b1; dir = 1'b0;
    step_chk("os1", 1, 1, 0, 0);
    step_chk("os2", 2, 2, 0, 0);
    step_chk("os3", 3, 3, 0, 0);
    check("os3.done", 32'(done), 0);
    step_chk("os4", 3, 3, 0, 0);
    check("os4.done", 32'(done), 1);
    step_chk("os5", 3, 3, 0, 0);
    check("os5.done", 32'(done), 1);
    en = 1'b0; ld = 1'b1; ld_idx = 2'd0;
    step_chk("osld", 0, 0, 0, 0);
    check("osld.done", 32'(done), 0);
    ld = 1'b0; oneshot = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_seq_counter.md
PROG_SEQ_COUNTER -- requirements
Module: prog_seq_counter

Interface
REQ-001 SHALL have parameter W, default 3, width of each sequence code and of q.
REQ-002 SHALL have parameter DEPTH, default 4 (range 2..256), number of sequence table entries; AW = clog2(DEPTH).
REQ-003 SHALL have port clk  in  1  clock; all state changes on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  in  1  advance one sequence step this cycle.
REQ-006 SHALL have port dir  in  1  0 = forward (idx+1), 1 = reverse (idx-1).
REQ-007 SHALL have port ld  in  1  synchronous load of ld_idx into idx.
REQ-008 SHALL have port ld_idx  in  AW  index to load.
REQ-009 SHALL have port last_idx  in  AW  final active table entry; values >= DEPTH are clamped to DEPTH-1.
REQ-010 SHALL have port wr_en  in  1  table write strobe.
REQ-011 SHALL have port wr_addr  in  AW  table entry to write; wr_addr >= DEPTH is ignored.
REQ-012 SHALL have port wr_data  in  W  code to write.
REQ-013 SHALL have port err_clr  in  1  clears err.
REQ-014 SHALL have port q  out  W  registered code = table[idx].
REQ-015 SHALL have port idx  out  AW  registered current table index.
REQ-016 SHALL have port wrap  out  1  one-cycle pulse on sequence wrap.
REQ-017 SHALL have port err  out  1  sticky illegal-index flag.

Function
REQ-018 SHALL update idx each cycle with priority: ld > en > hold.
REQ-019 SHALL on forward step go to idx+1 if idx < L, else to 0, where L = clamped last_idx.
REQ-020 SHALL on reverse step go to idx-1 if 0 < idx <= L, else to L.
REQ-021 SHALL pulse wrap for exactly the cycle after a step from L to 0 (forward) or from 0 to L (reverse); ld SHALL never assert wrap.
REQ-022 SHALL, when ld with ld_idx > L, load idx = 0 and set err; a legal ld SHALL NOT set err.
REQ-023 SHALL, when idx > L after last_idx is lowered, treat the next forward step as a wrap to 0 and the next reverse step as a move to L; err is unaffected.
REQ-024 SHALL register q <= table'[idx'], where idx' is the next index and table' includes the same-cycle write (write-through, zero-cycle visibility).
REQ-025 SHALL refresh q every cycle, so a write to the current entry appears on q the next cycle even without en.
REQ-026 SHALL give err_clr priority below the set condition: simultaneous set and clear leaves err = 1.
REQ-027 SHALL ignore dir when en = 0 or ld = 1.

Reset
REQ-028 SHALL on rst set idx = 0, wrap = 0, err = 0 asynchronously.
REQ-029 SHALL on rst initialise table[i] = i mod 2^W, so q = 0 during and after reset and the default forward sequence is 0,1,2,...
REQ-030 SHALL abandon any in-progress step or write when rst asserts mid-cycle; first step after release starts from idx 0.

Configuration
REQ-031 SHALL, with macro PROG_SEQ_COUNTER_ONESHOT_EN defined, add input oneshot (1) and output done (1): when oneshot = 1, a step that would wrap instead holds idx, suppresses wrap, and sets done; done clears on ld or rst.
REQ-032 SHALL, without PROG_SEQ_COUNTER_ONESHOT_EN, omit the oneshot and done ports and always wrap freely.

Verification
REQ-033 SHALL check: reset release, en = 1, dir = 0, W = 3, DEPTH = 4, table {0,1,2,7} written -> q = 0,1,2,7,0; wrap high on the cycle q returns to 0.
REQ-034 SHALL check: dir = 1 from idx 0, L = 3 -> idx 3,2,1,0,3; wrap on the first and last steps.
REQ-035 SHALL check: ld = 1, ld_idx = 3, last_idx = 2 -> idx = 0 and err = 1; err_clr with no set -> err = 0; simultaneous set and clear -> err stays 1.
REQ-036 SHALL check: wr_en to the current idx with en = 0, wr_data = 5 -> q = 5 next cycle; write to idx' in the same cycle as a step -> new value on q.
REQ-037 SHALL check: rst pulsed mid-sequence at idx 2 -> q = 0, idx = 0, table restored to identity.
REQ-038 SHALL check, with PROG_SEQ_COUNTER_ONESHOT_EN and oneshot = 1: forward run stops at idx 3, done = 1, wrap never pulses; ld 0 clears done.
